// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: adds two WIDTH-bit operands one nibble per clock
// through a single shared 4-bit ripple adder (fulladd4), LSB nibble first.
// Optional feature: define SUB_EN to add a 'sub' input (a - b via a + ~b + 1).

// 4-bit ripple-carry adder built from per-bit full adders.
module fulladd4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [4:0] carry;

  assign carry[0] = c_in;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bit
      assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign c_out = carry[4];

endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             carry_reg, carry_next;
  logic [IDXW-1:0]  idx_reg, idx_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             c_out_reg, c_out_next;

  // Operand B and initial carry as latched at acceptance; subtraction
  // inverts B and forces the carry so the adder produces a + ~b + 1.
  logic [WIDTH-1:0] op_b;
  logic             op_carry;

`ifdef SUB_EN
  assign op_b     = sub ? ~b : b;
  assign op_carry = sub ? 1'b1 : c_in;
`else
  assign op_b     = b;
  assign op_carry = c_in;
`endif

  // Bit offset of the nibble currently being processed.
  logic [IDXW+1:0] nib_base;
  logic [3:0]      nib_a;
  logic [3:0]      nib_b;
  logic [3:0]      nib_sum;
  logic            nib_cout;

  assign nib_base = {idx_reg, 2'b00};
  assign nib_a    = a_reg[nib_base +: 4];
  assign nib_b    = b_reg[nib_base +: 4];

  fulladd4 u_fulladd4 (
    .a     (nib_a),
    .b     (nib_b),
    .c_in  (carry_reg),
    .sum   (nib_sum),
    .c_out (nib_cout)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers: latched operands, running carry, nibble index, result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      sum_reg   <= '0;
      c_out_reg <= 1'b0;
    end else begin
      a_reg     <= a_next;
      b_reg     <= b_next;
      carry_reg <= carry_next;
      idx_reg   <= idx_next;
      sum_reg   <= sum_next;
      c_out_reg <= c_out_next;
    end
  end

  // Next-state and datapath update: accept in IDLE, one nibble per RUN cycle.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    carry_next = carry_reg;
    idx_next   = idx_reg;
    sum_next   = sum_reg;
    c_out_next = c_out_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          a_next     = a;
          b_next     = op_b;
          carry_next = op_carry;
          idx_next   = '0;
          sum_next   = '0;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        sum_next[nib_base +: 4] = nib_sum;
        carry_next              = nib_cout;
        if (idx_reg == IDX_LAST) begin
          c_out_next = nib_cout;
          state_next = S_DONE;
        end else begin
          idx_next = idx_reg + IDXW'(1);
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign ready = (state_reg == S_IDLE);
  assign busy  = (state_reg == S_RUN);
  assign done  = (state_reg == S_DONE);
  assign sum   = sum_reg;
  assign c_out = c_out_reg;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (WIDTH=16, period 20).
// Builds with or without SUB_EN.
module tb_nibble_serial_add_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;
  localparam int TMO   = 50;

  logic             clock   = 1'b0;
  logic             reset_n = 1'b0;
  logic             start   = 1'b0;
  logic [WIDTH-1:0] a       = '0;
  logic [WIDTH-1:0] b       = '0;
  logic             c_in    = 1'b0;
`ifdef SUB_EN
  logic             sub     = 1'b0;
`endif
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  int tests = 0;
  int fails = 0;

  always #10 clock = ~clock;

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .c_in    (c_in),
`ifdef SUB_EN
    .sub     (sub),
`endif
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .c_out   (c_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: {carry/no-borrow, WIDTH-bit result}.
  function automatic logic [WIDTH:0] ref_result(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic ci, input logic s);
    logic [WIDTH:0] r;
    if (s) begin
      r[WIDTH-1:0] = x - y;
      r[WIDTH]     = (x >= y);
    end else begin
      r = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    end
    return r;
  endfunction

  logic cur_sub;
`ifdef SUB_EN
  assign cur_sub = sub;
`else
  assign cur_sub = 1'b0;
`endif

  // Behavioural model: phase -1 = idle, 0..NIB-1 = nibbles completed while
  // running, NIB = done cycle. Visible sum holds the low nibbles completed so far.
  int               m_phase = -1;
  logic [WIDTH:0]   m_res   = '0;
  logic [WIDTH-1:0] m_sum   = '0;
  logic             m_cout  = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = -1;
      m_sum   = '0;
      m_cout  = 1'b0;
    end else if (m_phase == -1) begin
      if (start) begin
        m_res   = ref_result(a, b, c_in, cur_sub);
        m_sum   = '0;
        m_phase = 0;
      end
    end else if (m_phase < NIB) begin
      m_sum   = m_res[WIDTH-1:0] & WIDTH'((64'd1 << (4 * (m_phase + 1))) - 64'd1);
      m_phase = m_phase + 1;
      if (m_phase == NIB) m_cout = m_res[WIDTH];
    end else begin
      m_phase = -1;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clock) begin
    chk("ready", ready, (m_phase == -1));
    chk("busy", busy, (m_phase >= 0 && m_phase < NIB));
    chk("done", done, (m_phase == NIB));
    chk("sum", sum, m_sum);
    if (m_phase == -1 || m_phase == NIB) chk("c_out", c_out, m_cout);
  end

  // One operation; optional spurious start while busy and literal expectations.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tci, input logic tsub, input bit spur,
                        input bit lit, input logic [WIDTH-1:0] esum, input logic ecout);
    int w = 0;
    int n = 0;
    int nbusy = 0;
    while (!ready && w < TMO) begin
      @(negedge clock);
      w++;
    end
    chk("wait_ready", ready, 1'b1);
    a = ta; b = tb_v; c_in = tci;
`ifdef SUB_EN
    sub = tsub;
`endif
    start = 1'b1;
    while (n < TMO) begin
      @(negedge clock);
      n++;
      if (busy) nbusy++;
      if (n == 1) begin
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'($urandom);
      end
      if (spur && n == 2) begin
        start = 1'b1;
        a = 16'h1111;
      end
      if (spur && n == 3) start = 1'b0;
      if (done) break;
    end
    chk("latency", n, NIB + 1);
    chk("busy_cycles", nbusy, NIB);
    if (lit) begin
      chk("sum_lit", sum, esum);
      chk("cout_lit", c_out, ecout);
    end
    $display("[TB] op a=%h b=%h c_in=%b sub=%b spur=%0d -> sum=%h c_out=%b cycles=%0d",
             ta, tb_v, tci, tsub, spur, sum, c_out, n);
    @(negedge clock);
    chk("ready_after", ready, 1'b1);
    if (lit) chk("sum_held", sum, esum);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clock);
    @(negedge clock);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, 16'h0000);
    chk("rst_cout", c_out, 1'b0);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed cases with hand-computed results
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1, 16'h0100, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1, 16'h0000, 1'b1);
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 0, 1, 16'h5556, 1'b0);
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 1, 1, 16'h5556, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0, 1, 16'hFFFF, 1'b1);
    run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 0, 1, 16'h0000, 1'b0);

    // Mid-RUN asynchronous reset
    a = 16'hABCD; b = 16'h1357; c_in = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_ready", ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_sum", sum, 16'h0000);
    chk("midrst_cout", c_out, 1'b0);
    $display("[TB] mid-run reset: ready=%b busy=%b sum=%h c_out=%b", ready, busy, sum, c_out);
    reset_n = 1'b1;
    @(negedge clock);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0, 1, 16'h0000, 1'b1);

`ifdef SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1, 16'hFFFE, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0, 1, 16'h0002, 1'b1);
    run_op(16'h1234, 16'h1234, 1'b0, 1'b1, 0, 1, 16'h0000, 1'b1);
`endif

    // Randomized operations, checked by the model every cycle
    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) @(negedge clock);
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
             1'($urandom), bit'($urandom_range(0, 1)), 0, '0, 1'b0);
    end

    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
